// File: rtl/srseq_pkg.sv
// Shared encodings and default sizes for the shift/rotate sequencer.
// Used by shift_rotate_seq and srseq_step_counter.
package srseq_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_SET      = 2'b01,
    OP_SHIFT_IN = 2'b10,
    OP_JOHNSON  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/srseq_step_counter.sv
// Remaining-step counter for the sequencer: loads on accept, counts down
// while running, flags the final step. Falling-edge clocked, async CLR.
module srseq_step_counter #(
  parameter int STEP_W = srseq_pkg::DEF_STEP_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              load,
  input  logic [STEP_W-1:0] load_val,
  input  logic              dec,
  output logic [STEP_W-1:0] cnt,
  output logic              last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == STEP_W'(1));

endmodule

// File: rtl/shift_rotate_seq.sv
// Command-driven shift/rotate register sequencer (clear, set, serial shift-in,
// Johnson rotate). Optional abort input/aborted flag under SRSEQ_ABORT_EN.
module shift_rotate_seq
  import srseq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic [WIDTH-1:0]  q,
`ifdef SRSEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done
);

  state_e             state, state_nxt;
  op_e                op_q;
  op_e                cmd_op_e;
  logic [WIDTH-1:0]   dreg;
  logic [STEP_W-1:0]  cnt;
  logic               last;
  logic               accept;
  logic               run_step;
  logic               abort_hit;
  logic               sin;

  assign cmd_op_e = op_e'(cmd_op);

`ifdef SRSEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  srseq_step_counter #(.STEP_W(STEP_W)) u_step_counter (
    .CLK      (CLK),
    .CLR      (CLR),
    .load     (accept),
    .load_val (cmd_steps),
    .dec      (run_step),
    .cnt      (cnt),
    .last     (last)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          if ((cmd_op_e == OP_CLEAR) || (cmd_op_e == OP_SET) || (cmd_steps == '0))
            state_nxt = ST_DONE;
          else
            state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_hit) begin
          state_nxt = ST_DONE;
        end else begin
          run_step = 1'b1;
          if (last) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift-in feeds the latched word MSB first; Johnson feeds back inverted MSB.
  assign sin = (op_q == OP_SHIFT_IN) ? dreg[WIDTH-1] : ~q[WIDTH-1];

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= ST_IDLE;
      op_q  <= OP_CLEAR;
      dreg  <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= cmd_op_e;
        dreg <= cmd_data;
        if (cmd_op_e == OP_CLEAR)
          q <= '0;
        else if (cmd_op_e == OP_SET)
          q <= '1;
      end else if (run_step) begin
        q <= {q[WIDTH-2:0], sin};
        if (op_q == OP_SHIFT_IN)
          dreg <= {dreg[WIDTH-2:0], dreg[WIDTH-1]};
      end
    end
  end

`ifdef SRSEQ_ABORT_EN
  // Set only by an abort in RUN, so it is high exactly during that DONE cycle.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR)
      aborted <= 1'b0;
    else
      aborted <= (state == ST_RUN) && abort;
  end
`endif

  assign cmd_ready = (state == ST_IDLE) && !CLR;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Self-checking bench for shift_rotate_seq: command table with scoreboard,
// plus hand-written reset, back-to-back and (SRSEQ_ABORT_EN) abort sequences.
module tb_shift_rotate_seq;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 4;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_SET   = 2'b01;
  localparam logic [1:0] C_SHIFT = 2'b10;
  localparam logic [1:0] C_JOHN  = 2'b11;

  logic              CLK = 1'b0;
  logic              clk_en = 1'b0;
  logic              CLR;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_steps;
  logic [WIDTH-1:0]  cmd_data;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic              abort;
  logic              aborted;

  shift_rotate_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_steps (cmd_steps),
    .cmd_data  (cmd_data),
    .q         (q),
`ifdef SRSEQ_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .busy      (busy),
    .done      (done)
  );

`ifndef SRSEQ_ABORT_EN
  assign aborted = 1'b0;
`endif

  always #5 if (clk_en) CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             done;
  } exp_t;

  typedef struct {
    logic [1:0]       op;
    int               steps;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_q;

  // Drives one command at a posedge in IDLE; model predicts q/done per cycle.
  task automatic send(input logic [1:0] op, input int steps, input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] mq, md;
    logic             sin;
    exp_t             e;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = STEP_W'(steps);
    cmd_data  = data;
    mq = model_q;
    md = data;
    if (op == C_CLEAR) begin
      mq = '0;
      exp_q.push_back('{mq, 1'b1});
    end else if (op == C_SET) begin
      mq = '1;
      exp_q.push_back('{mq, 1'b1});
    end else if (steps == 0) begin
      exp_q.push_back('{mq, 1'b1});
    end else begin
      exp_q.push_back('{mq, 1'b0});
      for (int k = 1; k <= steps; k++) begin
        if (op == C_SHIFT) begin
          sin = md[WIDTH-1];
          md  = {md[WIDTH-2:0], md[WIDTH-1]};
        end else begin
          sin = ~mq[WIDTH-1];
        end
        mq = {mq[WIDTH-2:0], sin};
        exp_q.push_back('{mq, (k == steps)});
      end
    end
    model_q = mq;
    @(posedge CLK);
    cmd_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("run_q", q, e.q);
      check("run_done", done, e.done);
      check("run_busy", busy, 1);
      check("run_ready", cmd_ready, 0);
      if (e.done) check("aborted_normal", aborted, 0);
      if (exp_q.size() > 0) @(posedge CLK);
    end
    @(posedge CLK);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{C_SET,    0, 4'b0000, 4'b1111};
    vecs[1] = '{C_SHIFT,  4, 4'b1010, 4'b1010};
    vecs[2] = '{C_CLEAR,  0, 4'b0000, 4'b0000};
    vecs[3] = '{C_JOHN,   8, 4'b0000, 4'b0000};
    vecs[4] = '{C_SHIFT,  6, 4'b1100, 4'b0011};
    vecs[5] = '{C_JOHN,   0, 4'b0000, 4'b0011};
    vecs[6] = '{C_JOHN,   3, 4'b0000, 4'b1110};
    vecs[7] = '{C_SHIFT,  1, 4'b0110, 4'b1100};
    vecs[8] = '{C_SHIFT, 15, 4'b1001, 4'b1100};
    vecs[9] = '{C_SET,    0, 4'b0000, 4'b1111};

    CLR = 1'b0; cmd_valid = 1'b0; cmd_op = C_CLEAR;
    cmd_steps = '0; cmd_data = '0; abort = 1'b0;
    model_q = '0;

    // Reset with the clock stopped
    #3 CLR = 1'b1;
    #1;
    check("rst_q", q, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 CLR = 1'b0;
    #1 check("rst_ready", cmd_ready, 1);

    clk_en = 1'b1;
    @(posedge CLK);

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].steps, vecs[i].data);
      check($sformatf("vec%0d_final_q", i), q, vecs[i].exp_q);
    end

    // Held cmd_valid: second command waits for IDLE after done
    cmd_valid = 1'b1; cmd_op = C_CLEAR; cmd_steps = '0;
    @(posedge CLK);
    check("b2b_done1", done, 1);
    check("b2b_q1", q, 4'b0000);
    check("b2b_ready_done", cmd_ready, 0);
    cmd_op = C_JOHN; cmd_steps = 4'd2;
    @(posedge CLK);
    check("b2b_ready_idle", cmd_ready, 1);
    check("b2b_busy_idle", busy, 0);
    check("b2b_q_idle", q, 4'b0000);
    @(posedge CLK);
    check("b2b_busy_run", busy, 1);
    check("b2b_ready_run0", cmd_ready, 0);
    check("b2b_q_run0", q, 4'b0000);
    @(posedge CLK);
    check("b2b_ready_run1", cmd_ready, 0);
    check("b2b_q_run1", q, 4'b0001);
    @(posedge CLK);
    check("b2b_done2", done, 1);
    check("b2b_q2", q, 4'b0011);
    check("b2b_ready_done2", cmd_ready, 0);
    cmd_valid = 1'b0;
    @(posedge CLK);
    check("b2b_ready_end", cmd_ready, 1);
    check("b2b_done_end", done, 0);
    model_q = 4'b0011;

    // CLR during RUN at step 2 of 5
    send(C_CLEAR, 0, 4'b0000);
    cmd_valid = 1'b1; cmd_op = C_JOHN; cmd_steps = 4'd5;
    @(posedge CLK);
    cmd_valid = 1'b0;
    check("mid_q0", q, 4'b0000);
    @(posedge CLK);
    check("mid_q1", q, 4'b0001);
    @(posedge CLK);
    check("mid_q2", q, 4'b0011);
    #2 CLR = 1'b1;
    #1;
    check("mid_rst_q", q, 4'b0000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    #1 CLR = 1'b0;
    #1 check("mid_rst_ready", cmd_ready, 1);
    model_q = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      check("mid_no_done", done, 0);
      check("mid_idle", busy, 0);
    end

`ifdef SRSEQ_ABORT_EN
    cmd_valid = 1'b1; cmd_op = C_JOHN; cmd_steps = 4'd5;
    @(posedge CLK);
    cmd_valid = 1'b0;
    @(posedge CLK);
    check("ab_q1", q, 4'b0001);
    @(posedge CLK);
    check("ab_q2", q, 4'b0011);
    abort = 1'b1;
    @(posedge CLK);
    abort = 1'b0;
    check("ab_q_hold", q, 4'b0011);
    check("ab_done", done, 1);
    check("ab_aborted", aborted, 1);
    @(posedge CLK);
    check("ab_done_clr", done, 0);
    check("ab_aborted_clr", aborted, 0);
    check("ab_ready", cmd_ready, 1);
    abort = 1'b1;
    @(posedge CLK);
    abort = 1'b0;
    check("ab_idle_ignored_busy", busy, 0);
    check("ab_idle_ignored_aborted", aborted, 0);
    check("ab_idle_q", q, 4'b0011);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
